// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Provides the state encoding, the requester-id constants and a counter-width
// helper used to size the timeout and gap counters.
package uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    // Requester ids; also the bit positions in the arbiter's one-hot grant.
    localparam logic REQ_RF  = 1'b0;
    localparam logic REQ_ALU = 1'b1;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Two-way round-robin arbiter between the register-file and ALU requesters.
// Ports:
//   req_rf, req_alu : request inputs
//   ptr             : side preferred on a tie (REQ_RF / REQ_ALU)
//   grant_c         : one-hot grant, bit REQ_RF / REQ_ALU (combinational)
//   flip_c          : pointer must toggle; only on a tie (combinational)
module uart_tx_rr_arb (
    input  logic       req_rf,
    input  logic       req_alu,
    input  logic       ptr,
    output logic [1:0] grant_c,
    output logic       flip_c
);
    import uart_tx_scheduler_pkg::*;

    // A lone request always wins; a tie goes to the pointer's side.
    always_comb begin
        grant_c = 2'b00;
        flip_c  = 1'b0;
        if (req_rf && req_alu) begin
            grant_c[ptr] = 1'b1;
            flip_c       = 1'b1;
        end else if (req_rf) begin
            grant_c[REQ_RF] = 1'b1;
        end else if (req_alu) begin
            grant_c[REQ_ALU] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between a 1-byte register-file path and a
// 2-byte (LSB first) ALU result path. Paces on TX_BUSY, inserts a GAP-cycle
// idle gap after every byte and retransmits when the transmitter ignores a
// strobe for TMO cycles.
// Ports:
//   CLK, RST             : clock, synchronous active-low reset
//   RF_RD_DATA/RF_RD_VLD : register-file byte request
//   ALU_OUT/ALU_OUT_VLD  : ALU 2-byte request
//   TX_BUSY              : transmitter busy flag
//   RF_ACK/ALU_ACK       : one-cycle capture pulses
//   TX_P_DATA/TX_D_VLD   : byte and strobe to the transmitter
//   SCHED_BUSY           : transfer in progress (grant+1 .. last gap cycle)
//   TMO_ERR              : one-cycle pulse per timeout retransmit
module uart_tx_scheduler #(
    parameter int unsigned width = 8,
    parameter int unsigned GAP   = 2,
    parameter int unsigned TMO   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [width-1:0]     RF_RD_DATA,
    input  logic                 RF_RD_VLD,
    input  logic [2*width-1:0]   ALU_OUT,
    input  logic                 ALU_OUT_VLD,
    input  logic                 TX_BUSY,
    output logic                 RF_ACK,
    output logic                 ALU_ACK,
    output logic [width-1:0]     TX_P_DATA,
    output logic                 TX_D_VLD,
    output logic                 SCHED_BUSY,
    output logic                 TMO_ERR
);
    import uart_tx_scheduler_pkg::*;

    localparam int unsigned HW = 2 * width;
    localparam int unsigned TW = cnt_width(TMO);
    localparam int unsigned GW = cnt_width(GAP);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP == 0) ? 0 : GAP - 1);

    state_t          state, state_n;
    logic [HW-1:0]   hold, hold_n;
    logic [1:0]      bytes_left, bytes_n;
    logic [TW-1:0]   tmo_cnt, tmo_n;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic            rr_ptr, ptr_n;
    logic            rf_ack_n, alu_ack_n, d_vld_n, tmo_err_n, sched_busy_n;
    logic [width-1:0] p_data_n;
    logic [1:0]      grant;
    logic            flip;

    uart_tx_rr_arb u_arb (
        .req_rf  (RF_RD_VLD),
        .req_alu (ALU_OUT_VLD),
        .ptr     (rr_ptr),
        .grant_c (grant),
        .flip_c  (flip)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= ST_IDLE;
            hold       <= '0;
            bytes_left <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            rr_ptr     <= REQ_RF;
            RF_ACK     <= 1'b0;
            ALU_ACK    <= 1'b0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            SCHED_BUSY <= 1'b0;
            TMO_ERR    <= 1'b0;
        end else begin
            state      <= state_n;
            hold       <= hold_n;
            bytes_left <= bytes_n;
            tmo_cnt    <= tmo_n;
            gap_cnt    <= gap_n;
            rr_ptr     <= ptr_n;
            RF_ACK     <= rf_ack_n;
            ALU_ACK    <= alu_ack_n;
            TX_P_DATA  <= p_data_n;
            TX_D_VLD   <= d_vld_n;
            SCHED_BUSY <= sched_busy_n;
            TMO_ERR    <= tmo_err_n;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_n   = state;
        hold_n    = hold;
        bytes_n   = bytes_left;
        tmo_n     = tmo_cnt;
        gap_n     = gap_cnt;
        ptr_n     = rr_ptr;
        rf_ack_n  = 1'b0;
        alu_ack_n = 1'b0;
        d_vld_n   = 1'b0;
        tmo_err_n = 1'b0;
        p_data_n  = TX_P_DATA;

        unique case (state)
            ST_IDLE: begin
                if (grant[REQ_RF]) begin
                    hold_n   = HW'(RF_RD_DATA);
                    bytes_n  = 2'd1;
                    rf_ack_n = 1'b1;
                    state_n  = ST_LOAD;
                end else if (grant[REQ_ALU]) begin
                    hold_n    = ALU_OUT;
                    bytes_n   = 2'd2;
                    alu_ack_n = 1'b1;
                    state_n   = ST_LOAD;
                end
                if (flip) begin
                    ptr_n = ~rr_ptr;
                end
            end
            ST_LOAD: begin
                tmo_n   = '0;
                state_n = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                // A busy flag already high (stale frame) is accepted as the rise.
                if (TX_BUSY) begin
                    state_n = ST_WAIT_LO;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_err_n = 1'b1;
                    state_n   = ST_LOAD;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!TX_BUSY) begin
                    bytes_n = bytes_left - 2'd1;
                    hold_n  = hold >> width;
                    gap_n   = '0;
                    if (GAP == 0) begin
                        state_n = (bytes_n != 2'd0) ? ST_LOAD : ST_IDLE;
                    end else begin
                        state_n = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = (bytes_left != 2'd0) ? ST_LOAD : ST_IDLE;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Strobe and byte are registered so they appear during the LOAD cycle.
        if (state_n == ST_LOAD) begin
            d_vld_n  = 1'b1;
            p_data_n = hold_n[width-1:0];
        end
        sched_busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a GAP=2 instance driven from a
// vector table plus hand sequences, and a GAP=0 instance for the no-gap case.
// Cycle offsets k count negedges after the cycle in which the request is
// driven (k=0 is the grant cycle).
module tb_uart_tx_scheduler;

    localparam int BUDGET = 150;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        rf_vld, alu_vld;
    logic [7:0]  rf_data;
    logic [15:0] alu_data;
    logic        stale;
    int          ignore_idx;

    logic        a_rf_vld, a_alu_vld, a_busy;
    logic        a_rf_ack, a_alu_ack, a_dvld, a_sbusy, a_tmo;
    logic [7:0]  a_pdata;
    logic        z_rf_vld, z_alu_vld, z_busy;
    logic        z_rf_ack, z_alu_ack, z_dvld, z_sbusy, z_tmo;
    logic [7:0]  z_pdata;

    assign a_rf_vld  = rf_vld  & ~sel;
    assign a_alu_vld = alu_vld & ~sel;
    assign z_rf_vld  = rf_vld  & sel;
    assign z_alu_vld = alu_vld & sel;

    uart_tx_scheduler #(.width(8), .GAP(2), .TMO(16)) dut (
        .CLK(clk), .RST(rst),
        .RF_RD_DATA(rf_data), .RF_RD_VLD(a_rf_vld),
        .ALU_OUT(alu_data), .ALU_OUT_VLD(a_alu_vld),
        .TX_BUSY(a_busy),
        .RF_ACK(a_rf_ack), .ALU_ACK(a_alu_ack),
        .TX_P_DATA(a_pdata), .TX_D_VLD(a_dvld),
        .SCHED_BUSY(a_sbusy), .TMO_ERR(a_tmo)
    );

    uart_tx_scheduler #(.width(8), .GAP(0), .TMO(16)) dut_g0 (
        .CLK(clk), .RST(rst),
        .RF_RD_DATA(rf_data), .RF_RD_VLD(z_rf_vld),
        .ALU_OUT(alu_data), .ALU_OUT_VLD(z_alu_vld),
        .TX_BUSY(z_busy),
        .RF_ACK(z_rf_ack), .ALU_ACK(z_alu_ack),
        .TX_P_DATA(z_pdata), .TX_D_VLD(z_dvld),
        .SCHED_BUSY(z_sbusy), .TMO_ERR(z_tmo)
    );

    // Transmitter models: busy for 10 cycles starting the cycle after a strobe.
    int a_left = 0;
    int a_strobes = 0;
    int z_left = 0;
    always @(posedge clk) begin
        if (!rst) begin
            a_left <= 0;
        end else if (a_dvld) begin
            a_strobes <= a_strobes + 1;
            if (a_strobes != ignore_idx) a_left <= 10;
        end else if (a_left != 0) begin
            a_left <= a_left - 1;
        end
    end
    assign a_busy = (a_left != 0) || stale;

    always @(posedge clk) begin
        if (!rst) z_left <= 0;
        else if (z_dvld) z_left <= 10;
        else if (z_left != 0) z_left <= z_left - 1;
    end
    assign z_busy = (z_left != 0);

    // Observed outputs of the selected instance.
    logic       o_rf_ack, o_alu_ack, o_dvld, o_sbusy, o_tmo;
    logic [7:0] o_pdata;
    assign o_rf_ack  = sel ? z_rf_ack  : a_rf_ack;
    assign o_alu_ack = sel ? z_alu_ack : a_alu_ack;
    assign o_dvld    = sel ? z_dvld    : a_dvld;
    assign o_sbusy   = sel ? z_sbusy   : a_sbusy;
    assign o_tmo     = sel ? z_tmo     : a_tmo;
    assign o_pdata   = sel ? z_pdata   : a_pdata;

    int errors = 0;
    int checks = 0;

    int         r_n, r_end, r_first, r_first_ack_k, r_acks, r_tmo;
    logic [7:0] r_d [4];
    int         r_k [4];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Drive a request set from a negedge and record everything until idle.
    task automatic run_txn(input string name, input logic rv, input logic av,
                           input logic [7:0] rd, input logic [15:0] ad, input int stale_k);
        int   k;
        logic rp, ap, done;
        rf_data = rd; alu_data = ad; rf_vld = rv; alu_vld = av;
        rp = rv; ap = av;
        r_n = 0; r_end = -1; r_first = -1; r_first_ack_k = -1; r_acks = 0; r_tmo = 0;
        for (int i = 0; i < 4; i++) begin
            r_d[i] = 8'h00;
            r_k[i] = -1;
        end
        k = 0;
        done = 1'b0;
        while (!done && k < BUDGET) begin
            @(negedge clk);
            k++;
            if (o_rf_ack) begin
                r_acks++;
                if (r_first < 0) begin r_first = 0; r_first_ack_k = k; end
                rf_vld = 1'b0; rp = 1'b0;
            end
            if (o_alu_ack) begin
                r_acks++;
                if (r_first < 0) begin r_first = 1; r_first_ack_k = k; end
                alu_vld = 1'b0; ap = 1'b0;
            end
            if (o_dvld) begin
                if (r_n < 4) begin r_d[r_n] = o_pdata; r_k[r_n] = k; end
                r_n++;
            end
            if (o_tmo) r_tmo++;
            if (k == stale_k) stale = 1'b0;
            if (!rp && !ap && !o_sbusy) begin
                done  = 1'b1;
                r_end = k;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no idle within %0d cycles", name, BUDGET);
            rf_vld = 1'b0; alu_vld = 1'b0; stale = 1'b0;
        end
    endtask

    typedef struct {
        logic        rv;
        logic        av;
        logic [7:0]  rd;
        logic [15:0] ad;
        logic        ign;
        logic        stl;
        int          first;
        int          n;
        logic [31:0] bytes;
        int          k0;
        int          klast;
        int          kend;
        int          tmo;
    } vec_t;

    task automatic check_run(input string name, input vec_t v);
        chk({name, "_first"}, r_first, v.first);
        chk({name, "_ack_k"}, r_first_ack_k, 1);
        chk({name, "_acks"}, r_acks, int'(v.rv) + int'(v.av));
        chk({name, "_nstrobe"}, r_n, v.n);
        for (int j = 0; j < v.n && j < 4; j++) begin
            chk($sformatf("%s_byte%0d", name, j), int'(r_d[j]), int'(v.bytes[j*8 +: 8]));
        end
        chk({name, "_k0"}, r_k[0], v.k0);
        if (v.n >= 1 && v.n <= 4) chk({name, "_klast"}, r_k[v.n-1], v.klast);
        chk({name, "_end"}, r_end, v.kend);
        chk({name, "_tmo"}, r_tmo, v.tmo);
    endtask

    vec_t tbl [8];
    vec_t hv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rv av rd ad ign stl first n bytes{b3,b2,b1,b0} k0 klast end tmo
        tbl[0] = '{1'b1, 1'b0, 8'hA5, 16'h0000, 1'b0, 1'b0, 0, 1, 32'h000000A5, 1,  1, 15, 0};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 16'h1234, 1'b0, 1'b0, 1, 2, 32'h00001234, 1, 15, 29, 0};
        tbl[2] = '{1'b1, 1'b1, 8'h5A, 16'hBEEF, 1'b0, 1'b0, 0, 3, 32'h00BEEF5A, 1, 30, 44, 0};
        tbl[3] = '{1'b1, 1'b1, 8'hC3, 16'h0102, 1'b0, 1'b0, 1, 3, 32'h00C30102, 1, 30, 44, 0};
        tbl[4] = '{1'b1, 1'b1, 8'hFF, 16'h8000, 1'b0, 1'b0, 0, 3, 32'h008000FF, 1, 30, 44, 0};
        tbl[5] = '{1'b1, 1'b0, 8'h3C, 16'h0000, 1'b1, 1'b0, 0, 2, 32'h00003C3C, 1, 18, 32, 1};
        tbl[6] = '{1'b1, 1'b0, 8'h11, 16'h0000, 1'b1, 1'b1, 0, 1, 32'h00000011, 1,  1,  7, 0};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 16'h00FF, 1'b0, 1'b0, 1, 2, 32'h000000FF, 1, 15, 29, 0};

        rst = 1'b0; sel = 1'b0; rf_vld = 1'b0; alu_vld = 1'b0;
        rf_data = 8'h00; alu_data = 16'h0000; stale = 1'b0; ignore_idx = -1;
        repeat (3) @(negedge clk);
        chk("reset_outs_gap2", int'({a_rf_ack, a_alu_ack, a_pdata, a_dvld, a_sbusy, a_tmo}), 0);
        chk("reset_outs_gap0", int'({z_rf_ack, z_alu_ack, z_pdata, z_dvld, z_sbusy, z_tmo}), 0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ignore_idx = tbl[i].ign ? a_strobes : -1;
            stale      = tbl[i].stl;
            run_txn($sformatf("vec%0d", i), tbl[i].rv, tbl[i].av, tbl[i].rd, tbl[i].ad,
                    tbl[i].stl ? 4 : -1);
            check_run($sformatf("vec%0d", i), tbl[i]);
        end
        ignore_idx = -1;

        // Reset during WAIT_LO of the ALU first byte, RF request pending.
        alu_data = 16'h1234;
        alu_vld  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (a_alu_ack) alu_vld = 1'b0;
        end
        chk("rst_mid_in_wait_lo", int'({a_sbusy, a_busy}), 3);
        rst = 1'b0;
        rf_data = 8'h77;
        rf_vld  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_outs%0d", k),
                int'({a_rf_ack, a_alu_ack, a_pdata, a_dvld, a_sbusy, a_tmo}), 0);
        end
        rst = 1'b1;
        run_txn("after_rst", 1'b1, 1'b0, 8'h77, 16'h0000, -1);
        hv = '{1'b1, 1'b0, 8'h77, 16'h0000, 1'b0, 1'b0, 0, 1, 32'h00000077, 1, 1, 15, 0};
        check_run("after_rst", hv);

        // Tie after reset: pointer is back on RF.
        run_txn("tie_after_rst", 1'b1, 1'b1, 8'h42, 16'hA55A, -1);
        hv = '{1'b1, 1'b1, 8'h42, 16'hA55A, 1'b0, 1'b0, 0, 3, 32'h00A55A42, 1, 30, 44, 0};
        check_run("tie_after_rst", hv);

        // GAP=0 instance: second byte strobed the cycle after busy falls.
        sel = 1'b1;
        run_txn("gap0_alu", 1'b0, 1'b1, 8'h00, 16'h1234, -1);
        hv = '{1'b0, 1'b1, 8'h00, 16'h1234, 1'b0, 1'b0, 1, 2, 32'h00001234, 1, 13, 25, 0};
        check_run("gap0_alu", hv);
        run_txn("gap0_rf", 1'b1, 1'b0, 8'h96, 16'h0000, -1);
        hv = '{1'b1, 1'b0, 8'h96, 16'h0000, 1'b0, 1'b0, 0, 1, 32'h00000096, 1, 1, 13, 0};
        check_run("gap0_rf", hv);
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
